// File: rtl/dma_memc_stream_arb_pkg.sv
// Shared types for the multi-stream DMA-to-memory-controller arbiter.
// Stream ids are sized for the largest supported lane so every instance shares one type.
package dma_memc_arb_pkg;

   localparam int MAX_STREAMS = 8;

   typedef logic [$clog2(MAX_STREAMS)-1:0] stream_id_t;

   typedef enum logic {
      OP_WR = 1'b0,
      OP_RD = 1'b1
   } op_sel_e;

   // (base + off) mod n, valid for base < n and off <= n
   function automatic stream_id_t rr_next(stream_id_t base, int unsigned off, int unsigned n);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= n) sum = sum - n;
      return stream_id_t'(sum);
   endfunction

endpackage

// File: rtl/dma_memc_stream_arb_if.sv
// DMA-stream and memory-controller signals of one lane; slave = arbiter, master = environment.
interface dma_memc_stream_arb_if #(
   parameter int NUM_STREAMS = 2,
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 32,
   parameter int MAX_OUTST   = 4
);
   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   logic [NUM_STREAMS-1:0]        dma__memc__write_valid;
   logic [NUM_STREAMS*ADDR_W-1:0] dma__memc__write_address;
   logic [NUM_STREAMS*DATA_W-1:0] dma__memc__write_data;
   logic [NUM_STREAMS-1:0]        memc__dma__write_ready;
   logic [NUM_STREAMS-1:0]        dma__memc__read_valid;
   logic [NUM_STREAMS*ADDR_W-1:0] dma__memc__read_address;
   logic [NUM_STREAMS-1:0]        dma__memc__read_pause;
   logic [NUM_STREAMS-1:0]        memc__dma__read_ready;
   logic [NUM_STREAMS-1:0]        memc__dma__read_data_valid;
   logic [DATA_W-1:0]             memc__dma__read_data;
   logic                          arb__mem__valid;
   logic                          arb__mem__write;
   logic [ADDR_W-1:0]             arb__mem__address;
   logic [DATA_W-1:0]             arb__mem__wdata;
   logic                          mem__arb__ready;
   logic                          mem__arb__rdata_valid;
   logic [DATA_W-1:0]             mem__arb__rdata;
   logic [CNT_W-1:0]              arb__outstanding;
   logic                          arb__err_unexp_rdata;

   modport slave (
      input  dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
      input  dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
      input  mem__arb__ready, mem__arb__rdata_valid, mem__arb__rdata,
      output memc__dma__write_ready, memc__dma__read_ready,
      output memc__dma__read_data_valid, memc__dma__read_data,
      output arb__mem__valid, arb__mem__write, arb__mem__address, arb__mem__wdata,
      output arb__outstanding, arb__err_unexp_rdata
   );

   modport master (
      output dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
      output dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
      output mem__arb__ready, mem__arb__rdata_valid, mem__arb__rdata,
      input  memc__dma__write_ready, memc__dma__read_ready,
      input  memc__dma__read_data_valid, memc__dma__read_data,
      input  arb__mem__valid, arb__mem__write, arb__mem__address, arb__mem__wdata,
      input  arb__outstanding, arb__err_unexp_rdata
   );

endinterface

// File: rtl/dma_memc_tag_fifo.sv
// In-order FIFO of issuing stream ids for reads in flight; reset flushes every entry.
// Count, full and empty are registered; a same-cycle pop never frees a slot for a push.
module dma_memc_tag_fifo
   import dma_memc_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_poweron,
   input  logic             i_push,
   input  stream_id_t       i_push_id,
   input  logic             i_pop,
   output stream_id_t       o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTR_W = $clog2(DEPTH);

   stream_id_t       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + PTR_W'(1);
         if (w_pop)  r_rp <= r_rp + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_push_id;
   end

   assign o_head  = r_mem[r_rp];
   assign o_count = r_count;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/dma_memc_stream_arb.sv
// Round-robin arbiter of NUM_STREAMS DMA streams onto one memory port, zero-latency requests;
// read returns are steered to the issuing stream one cycle later and are never stalled.
module dma_memc_stream_arb
   import dma_memc_arb_pkg::*;
#(
   parameter int NUM_STREAMS = 2,
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 32,
   parameter int MAX_OUTST   = 4
) (
   input  logic                 clk,
   input  logic                 reset_poweron,
   dma_memc_stream_arb_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   logic [NUM_STREAMS-1:0] w_wr_el, w_rd_el, w_any;
   logic [NUM_STREAMS-1:0] w_wr_rdy, w_rd_rdy;
   logic                   w_fifo_full, w_fifo_empty;
   logic [CNT_W-1:0]       w_fifo_count;
   stream_id_t             w_head;
   logic                   w_found;
   stream_id_t             w_win;
   logic                   w_sel_wr, w_sel_rd, w_sel_prio;
   logic [ADDR_W-1:0]      w_sel_waddr, w_sel_raddr;
   logic [DATA_W-1:0]      w_sel_wdata;
   op_sel_e                w_op;
   logic                   w_req, w_hs, w_push, w_pop;

   stream_id_t             r_ptr;
   logic [NUM_STREAMS-1:0] r_wr_prio;
   logic [NUM_STREAMS-1:0] r_rd_vld;
   logic [DATA_W-1:0]      r_rd_data;
   logic                   r_err;

   // full is the registered count, so a pop this cycle does not re-open issue until next cycle
   assign w_wr_el = bus.dma__memc__write_valid;
   assign w_rd_el = bus.dma__memc__read_valid & ~bus.dma__memc__read_pause
                  & {NUM_STREAMS{~w_fifo_full}};
   assign w_any   = w_wr_el | w_rd_el;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
         for (int s = 0; s < NUM_STREAMS; s++) begin
            if (!w_found && w_any[s] && rr_next(r_ptr, i, NUM_STREAMS) == stream_id_t'(s)) begin
               w_found = 1'b1;
               w_win   = stream_id_t'(s);
            end
         end
      end
   end

   always_comb begin
      w_sel_wr    = 1'b0;
      w_sel_rd    = 1'b0;
      w_sel_prio  = 1'b0;
      w_sel_waddr = '0;
      w_sel_raddr = '0;
      w_sel_wdata = '0;
      for (int s = 0; s < NUM_STREAMS; s++) begin
         if (w_win == stream_id_t'(s)) begin
            w_sel_wr    = w_wr_el[s];
            w_sel_rd    = w_rd_el[s];
            w_sel_prio  = r_wr_prio[s];
            w_sel_waddr = bus.dma__memc__write_address[s*ADDR_W +: ADDR_W];
            w_sel_raddr = bus.dma__memc__read_address[s*ADDR_W +: ADDR_W];
            w_sel_wdata = bus.dma__memc__write_data[s*DATA_W +: DATA_W];
         end
      end
   end

   assign w_op   = (w_sel_wr && (!w_sel_rd || w_sel_prio)) ? OP_WR : OP_RD;
   assign w_req  = w_found & ~reset_poweron;
   assign w_hs   = w_req & bus.mem__arb__ready;
   assign w_push = w_hs & (w_op == OP_RD);
   assign w_pop  = bus.mem__arb__rdata_valid & ~w_fifo_empty;

   always_comb begin
      w_wr_rdy = '0;
      w_rd_rdy = '0;
      for (int s = 0; s < NUM_STREAMS; s++) begin
         w_wr_rdy[s] = w_hs && (w_op == OP_WR) && (w_win == stream_id_t'(s));
         w_rd_rdy[s] = w_hs && (w_op == OP_RD) && (w_win == stream_id_t'(s));
      end
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         r_ptr     <= '0;
         r_wr_prio <= '1;
         r_rd_vld  <= '0;
         r_rd_data <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_hs) begin
            r_ptr <= rr_next(w_win, 1, NUM_STREAMS);
            for (int s = 0; s < NUM_STREAMS; s++) begin
               if (w_sel_wr && w_sel_rd && w_win == stream_id_t'(s))
                  r_wr_prio[s] <= ~r_wr_prio[s];
            end
         end
         for (int s = 0; s < NUM_STREAMS; s++)
            r_rd_vld[s] <= w_pop && (w_head == stream_id_t'(s));
         if (w_pop) r_rd_data <= bus.mem__arb__rdata;
         if (bus.mem__arb__rdata_valid && w_fifo_empty) r_err <= 1'b1;
      end
   end

   dma_memc_tag_fifo #(
      .DEPTH (MAX_OUTST),
      .CNT_W (CNT_W)
   ) u_tag_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .i_push        (w_push),
      .i_push_id     (w_win),
      .i_pop         (w_pop),
      .o_head        (w_head),
      .o_count       (w_fifo_count),
      .o_full        (w_fifo_full),
      .o_empty       (w_fifo_empty)
   );

   assign bus.memc__dma__write_ready     = w_wr_rdy;
   assign bus.memc__dma__read_ready      = w_rd_rdy;
   assign bus.memc__dma__read_data_valid = r_rd_vld;
   assign bus.memc__dma__read_data       = r_rd_data;
   assign bus.arb__mem__valid            = w_req;
   assign bus.arb__mem__write            = w_req && (w_op == OP_WR);
   assign bus.arb__mem__address          = !w_req ? '0 : ((w_op == OP_WR) ? w_sel_waddr : w_sel_raddr);
   assign bus.arb__mem__wdata            = (w_req && w_op == OP_WR) ? w_sel_wdata : '0;
   assign bus.arb__outstanding           = w_fifo_count;
   assign bus.arb__err_unexp_rdata       = r_err;

endmodule

// File: tb/tb_dma_memc_stream_arb.sv
// Directed bench for dma_memc_stream_arb with two streams and a four-deep tag FIFO.
module tb_dma_memc_stream_arb;
   localparam int NS = 2;
   localparam int AW = 24;
   localparam int DW = 32;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n0, n1;

   dma_memc_stream_arb_if #(.NUM_STREAMS(NS), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) bus ();

   dma_memc_stream_arb #(.NUM_STREAMS(NS), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) u_dut (
      .clk           (clk),
      .reset_poweron (rst),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.dma__memc__write_valid   = '0;
      bus.dma__memc__write_address = '0;
      bus.dma__memc__write_data    = '0;
      bus.dma__memc__read_valid    = '0;
      bus.dma__memc__read_address  = '0;
      bus.dma__memc__read_pause    = '0;
      bus.mem__arb__ready          = 1'b0;
      bus.mem__arb__rdata_valid    = 1'b0;
      bus.mem__arb__rdata          = '0;

      // reset state
      tick();
      #1;
      chk("rst_outst", 32'(bus.arb__outstanding), 32'h0);
      chk("rst_err",   32'(bus.arb__err_unexp_rdata), 32'h0);
      chk("rst_rdv",   32'(bus.memc__dma__read_data_valid), 32'h0);
      chk("rst_valid", 32'(bus.arb__mem__valid), 32'h0);
      tick();
      rst = 1'b0;

      // continuous writes from both streams alternate s0, s1
      bus.dma__memc__write_valid   = 2'b11;
      bus.dma__memc__write_address = {24'h000B00, 24'h000A00};
      bus.dma__memc__write_data    = {32'hBBBB0001, 32'hAAAA0001};
      bus.mem__arb__ready          = 1'b1;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("t1_wr_rdy", 32'(bus.memc__dma__write_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
         chk("t1_addr", 32'(bus.arb__mem__address), (c % 2 == 0) ? 32'h000A00 : 32'h000B00);
         chk("t1_wdata", bus.arb__mem__wdata, (c % 2 == 0) ? 32'hAAAA0001 : 32'hBBBB0001);
         n0 += int'(bus.memc__dma__write_ready[0]);
         n1 += int'(bus.memc__dma__write_ready[1]);
         tick();
      end
      chk("t1_cnt_s0", 32'(n0), 32'd4);
      chk("t1_cnt_s1", 32'(n1), 32'd4);

      // s0 write+read together alternate; memory returns each read 3 cycles later
      bus.dma__memc__write_address = {24'h000000, 24'h000C00};
      bus.dma__memc__read_address  = {24'h000000, 24'h000D00};
      for (int c = 0; c < 12; c++) begin
         bus.dma__memc__write_valid = (c < 8) ? 2'b01 : 2'b00;
         bus.dma__memc__read_valid  = (c < 8) ? 2'b01 : 2'b00;
         bus.mem__arb__rdata_valid  = (c >= 4 && c <= 10 && c % 2 == 0);
         bus.mem__arb__rdata        = bus.mem__arb__rdata_valid ? 32'hD0000000 + 32'(c) : 32'h0;
         #1;
         if (c < 8) begin
            chk("t2_wr_rdy", 32'(bus.memc__dma__write_ready), (c % 2 == 0) ? 32'h1 : 32'h0);
            chk("t2_rd_rdy", 32'(bus.memc__dma__read_ready), (c % 2 == 1) ? 32'h1 : 32'h0);
            chk("t2_addr", 32'(bus.arb__mem__address), (c % 2 == 0) ? 32'h000C00 : 32'h000D00);
         end
         chk("t2_rdv", 32'(bus.memc__dma__read_data_valid),
             (c >= 5 && c % 2 == 1) ? 32'h1 : 32'h0);
         if (c >= 5 && c % 2 == 1)
            chk("t2_rdata", bus.memc__dma__read_data, 32'hD0000000 + 32'(c - 1));
         tick();
      end
      chk("t2_outst", 32'(bus.arb__outstanding), 32'h0);

      // fill the tag FIFO with reads s1, s0, s1, s0 (pointer now at s1)
      bus.dma__memc__read_valid   = 2'b11;
      bus.dma__memc__read_address = {24'h000E01, 24'h000E00};
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("t3_rd_rdy", 32'(bus.memc__dma__read_ready), (c % 2 == 0) ? 32'h2 : 32'h1);
         tick();
      end
      bus.dma__memc__read_valid = 2'b01;
      #1;
      chk("t3_outst_full", 32'(bus.arb__outstanding), 32'h4);
      chk("t3_full_rdy", 32'(bus.memc__dma__read_ready), 32'h0);
      chk("t3_full_valid", 32'(bus.arb__mem__valid), 32'h0);
      tick();
      bus.mem__arb__rdata_valid = 1'b1;
      bus.mem__arb__rdata       = 32'h11110001;
      #1;
      chk("t3_pop_cycle_rdy", 32'(bus.memc__dma__read_ready), 32'h0);
      tick();
      bus.mem__arb__rdata = 32'h11110002;
      #1;
      chk("t3_outst_after_pop", 32'(bus.arb__outstanding), 32'h3);
      chk("t3_fifth_rdy", 32'(bus.memc__dma__read_ready), 32'h1);
      chk("t3_rdv1", 32'(bus.memc__dma__read_data_valid), 32'h2);
      chk("t3_rdata1", bus.memc__dma__read_data, 32'h11110001);
      tick();
      bus.dma__memc__read_valid = 2'b00;
      bus.mem__arb__rdata       = 32'h11110003;
      #1;
      chk("t3_outst_pushpop", 32'(bus.arb__outstanding), 32'h3);
      chk("t3_rdv2", 32'(bus.memc__dma__read_data_valid), 32'h1);
      chk("t3_rdata2", bus.memc__dma__read_data, 32'h11110002);
      tick();
      bus.mem__arb__rdata = 32'h11110004;
      #1;
      chk("t3_rdv3", 32'(bus.memc__dma__read_data_valid), 32'h2);
      chk("t3_rdata3", bus.memc__dma__read_data, 32'h11110003);
      tick();
      bus.mem__arb__rdata = 32'h11110005;
      #1;
      chk("t3_rdv4", 32'(bus.memc__dma__read_data_valid), 32'h1);
      chk("t3_rdata4", bus.memc__dma__read_data, 32'h11110004);
      tick();
      bus.mem__arb__rdata_valid = 1'b0;
      bus.mem__arb__rdata       = 32'h0;
      #1;
      chk("t3_rdv5", 32'(bus.memc__dma__read_data_valid), 32'h1);
      chk("t3_rdata5", bus.memc__dma__read_data, 32'h11110005);
      chk("t3_outst_end", 32'(bus.arb__outstanding), 32'h0);
      tick();

      // s1 read paused while s0 writes; pointer sits at s1
      bus.dma__memc__write_valid   = 2'b01;
      bus.dma__memc__write_address = {24'h000000, 24'h000F00};
      bus.dma__memc__read_valid    = 2'b10;
      bus.dma__memc__read_address  = {24'h000F10, 24'h000000};
      bus.dma__memc__read_pause    = 2'b10;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("t4_pause_wr", 32'(bus.memc__dma__write_ready), 32'h1);
         chk("t4_pause_rd", 32'(bus.memc__dma__read_ready), 32'h0);
         tick();
      end
      bus.dma__memc__read_pause = 2'b00;
      #1;
      chk("t4_unpause_rd", 32'(bus.memc__dma__read_ready), 32'h2);
      chk("t4_unpause_wr", 32'(bus.memc__dma__write_ready), 32'h0);
      chk("t4_unpause_addr", 32'(bus.arb__mem__address), 32'h000F10);
      chk("t4_unpause_write", 32'(bus.arb__mem__write), 32'h0);
      tick();
      bus.dma__memc__read_valid = 2'b00;
      #1;
      chk("t4_next_wr", 32'(bus.memc__dma__write_ready), 32'h1);
      tick();
      bus.dma__memc__write_valid = 2'b00;
      bus.mem__arb__rdata_valid  = 1'b1;
      bus.mem__arb__rdata        = 32'h22220001;
      tick();
      bus.mem__arb__rdata_valid = 1'b0;
      bus.mem__arb__rdata       = 32'h0;
      #1;
      chk("t4_rdv", 32'(bus.memc__dma__read_data_valid), 32'h2);
      chk("t4_rdata", bus.memc__dma__read_data, 32'h22220001);
      tick();

      // memory stalls for 5 cycles; pointer (s1) must hold
      bus.dma__memc__write_valid   = 2'b11;
      bus.dma__memc__write_address = {24'h000B05, 24'h000A05};
      bus.mem__arb__ready          = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t5_stall_wr", 32'(bus.memc__dma__write_ready), 32'h0);
         chk("t5_stall_valid", 32'(bus.arb__mem__valid), 32'h1);
         chk("t5_stall_addr", 32'(bus.arb__mem__address), 32'h000B05);
         tick();
      end
      bus.mem__arb__ready = 1'b1;
      #1;
      chk("t5_first_grant", 32'(bus.memc__dma__write_ready), 32'h2);
      tick();
      #1;
      chk("t5_second_grant", 32'(bus.memc__dma__write_ready), 32'h1);
      tick();
      bus.dma__memc__write_valid = 2'b00;

      // unexpected return, sticky error, reset flush
      #1;
      chk("t6_outst_idle", 32'(bus.arb__outstanding), 32'h0);
      tick();
      bus.mem__arb__rdata_valid = 1'b1;
      bus.mem__arb__rdata       = 32'hDEAD0001;
      tick();
      bus.mem__arb__rdata_valid = 1'b0;
      #1;
      chk("t6_unexp_rdv", 32'(bus.memc__dma__read_data_valid), 32'h0);
      chk("t6_err_set", 32'(bus.arb__err_unexp_rdata), 32'h1);
      tick();
      #1;
      chk("t6_err_sticky", 32'(bus.arb__err_unexp_rdata), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_err_cleared", 32'(bus.arb__err_unexp_rdata), 32'h0);
      tick();
      bus.dma__memc__read_valid   = 2'b01;
      bus.dma__memc__read_address = {24'h000000, 24'h000123};
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t6_rd_rdy", 32'(bus.memc__dma__read_ready), 32'h1);
         tick();
      end
      bus.dma__memc__read_valid = 2'b00;
      #1;
      chk("t6_outst3", 32'(bus.arb__outstanding), 32'h3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_outst_flushed", 32'(bus.arb__outstanding), 32'h0);
      chk("t6_flush_rdv", 32'(bus.memc__dma__read_data_valid), 32'h0);
      tick();
      bus.mem__arb__rdata_valid = 1'b1;
      bus.mem__arb__rdata       = 32'hDEAD0002;
      tick();
      bus.mem__arb__rdata_valid = 1'b0;
      #1;
      chk("t6_stale_rdv", 32'(bus.memc__dma__read_data_valid), 32'h0);
      chk("t6_stale_err", 32'(bus.arb__err_unexp_rdata), 32'h1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
